// File: rtl/pt_pkg.sv
// Shared constants and FSM encoding for the PT2262-style OOK encoder/decoder pair.
// Widths are expressed as multiples of the timing unit alpha (in clk cycles).
package pt_pkg;

    localparam int FRAME_BITS    = 24;
    localparam int SHORT_MIN_DIV = 2;   // SHORT_MIN is half a unit, kept as a divisor
    localparam int LONG_MIN      = 2;
    localparam int LONG_MAX      = 4;
    localparam int SYNC_MIN      = 8;
    localparam int IDLE_MIN      = 64;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_BITS = 2'd1,
        ST_TAIL = 2'd2
    } pt_state_e;

    function automatic int cnt_width(input int alpha);
        return $clog2(IDLE_MIN * alpha + 1);
    endfunction

endpackage

// File: rtl/pt_sym_classify.sv
// Synchronizes the raw OOK line, measures high/low widths and classifies them.
// Width flags are combinational on the counter values; the decoder samples them at edges.
module pt_sym_classify
    import pt_pkg::*;
#(
    parameter int ALPHA = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic rise,
    output logic fall,
    output logic hi_short,
    output logic hi_long,
    output logic hi_over,
    output logic lo_short,
    output logic lo_long,
    output logic sync_hit,
    output logic idle_hit
);

    localparam int CW = cnt_width(ALPHA);
    localparam logic [CW-1:0] W_HALF = CW'(ALPHA / SHORT_MIN_DIV);
    localparam logic [CW-1:0] W_LMIN = CW'(LONG_MIN * ALPHA);
    localparam logic [CW-1:0] W_LMAX = CW'(LONG_MAX * ALPHA);
    localparam logic [CW-1:0] W_OVER = CW'(LONG_MAX * ALPHA + 1);
    localparam logic [CW-1:0] W_SYNC = CW'(SYNC_MIN * ALPHA);
    localparam logic [CW-1:0] W_IDLE = CW'(IDLE_MIN * ALPHA);

    logic          s1, s2, s3;
    logic [CW-1:0] hi_cnt, lo_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= line;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    // Each counter restarts at 1 on the edge that begins its level, so at the
    // opposite edge it holds the exact width of the level that just ended.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_cnt <= '0;
            lo_cnt <= '0;
        end else begin
            if (rise)
                hi_cnt <= CW'(1);
            else if (s2 && hi_cnt != W_IDLE)
                hi_cnt <= hi_cnt + CW'(1);

            if (fall)
                lo_cnt <= CW'(1);
            else if (!s2 && lo_cnt != W_IDLE)
                lo_cnt <= lo_cnt + CW'(1);
        end
    end

    assign hi_short = (hi_cnt >= W_HALF) && (hi_cnt < W_LMIN);
    assign hi_long  = (hi_cnt >= W_LMIN) && (hi_cnt <= W_LMAX);
    assign lo_short = (lo_cnt >= W_HALF) && (lo_cnt < W_LMIN);
    assign lo_long  = (lo_cnt >= W_LMIN) && (lo_cnt <= W_LMAX);

    // Edge cycles still hold the previous level's width, so they are excluded.
    assign hi_over  = s2 && !rise && (hi_cnt == W_OVER);
    assign sync_hit = !s2 && !fall && (lo_cnt == W_SYNC);
    assign idle_hit = !s2 && !fall && (lo_cnt == W_IDLE);

endmodule

// File: rtl/pt_dec.sv
// PT2262-style frame decoder: symbol FSM, payload shift register and repeat filter.
// A payload is reported once after MIN_REPEAT identical consecutive frames.
module pt_dec
    import pt_pkg::*;
#(
    parameter int ALPHA      = 16,
    parameter int MIN_REPEAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in,
    output logic [FRAME_BITS-1:0] data,
    output logic                  valid,
    output logic                  err
);

    localparam logic [2:0] REP      = 3'(MIN_REPEAT);
    localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

    logic rise, fall, hi_short, hi_long, hi_over, lo_short, lo_long, sync_hit, idle_hit;

    pt_state_e             state, state_nxt;
    logic                  have_hi, hi_short_q, hi_long_q;
    logic [4:0]            bit_cnt;
    logic [FRAME_BITS-1:0] shift_q, stored;
    logic [2:0]            match_cnt, cnt_new;
    logic                  hist_vld, pend, same, fire;
    logic                  err_ev, bit_ev, bit_val, done_ev;

    pt_sym_classify #(.ALPHA(ALPHA)) u_cls (
        .clk      (clk),
        .rst      (rst),
        .line     (in),
        .rise     (rise),
        .fall     (fall),
        .hi_short (hi_short),
        .hi_long  (hi_long),
        .hi_over  (hi_over),
        .lo_short (lo_short),
        .lo_long  (lo_long),
        .sync_hit (sync_hit),
        .idle_hit (idle_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_HUNT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_HUNT: if (sync_hit) state_nxt = ST_BITS;
            ST_BITS: begin
                if (err_ev)                              state_nxt = ST_HUNT;
                else if (bit_ev && bit_cnt == LAST_BIT)  state_nxt = ST_TAIL;
            end
            ST_TAIL: begin
                if (err_ev)       state_nxt = ST_HUNT;
                else if (done_ev) state_nxt = ST_BITS;
            end
            default: state_nxt = ST_HUNT;
        endcase
    end

    // The rise that ends the sync gap has no captured high yet, so it is not a symbol.
    always_comb begin
        err_ev  = 1'b0;
        bit_ev  = 1'b0;
        bit_val = 1'b0;
        done_ev = 1'b0;
        case (state)
            ST_BITS: begin
                if (hi_over)
                    err_ev = 1'b1;
                else if (fall)
                    err_ev = !(hi_short || hi_long);
                else if (rise && have_hi) begin
                    if (hi_long_q && lo_short) begin
                        bit_ev  = 1'b1;
                        bit_val = 1'b1;
                    end else if (hi_short_q && lo_long)
                        bit_ev = 1'b1;
                    else
                        err_ev = 1'b1;
                end else if (sync_hit)
                    err_ev = 1'b1;
            end
            ST_TAIL: begin
                if (hi_over)
                    err_ev = 1'b1;
                else if (fall)
                    err_ev = !hi_short;
                else if (rise)
                    err_ev = 1'b1;
                else if (sync_hit && have_hi)
                    done_ev = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        same    = hist_vld && (shift_q == stored);
        cnt_new = same ? ((match_cnt == 3'd7) ? 3'd7 : match_cnt + 3'd1) : 3'd1;
        fire    = done_ev && (cnt_new == REP) && !(same && match_cnt == REP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err        <= 1'b0;
            have_hi    <= 1'b0;
            hi_short_q <= 1'b0;
            hi_long_q  <= 1'b0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            stored     <= '0;
            match_cnt  <= '0;
            hist_vld   <= 1'b0;
            pend       <= 1'b0;
            valid      <= 1'b0;
            data       <= '0;
        end else begin
            err <= err_ev;
            if (fall) begin
                hi_short_q <= hi_short;
                hi_long_q  <= hi_long;
            end
            if (state_nxt == ST_HUNT || rise || done_ev)
                have_hi <= 1'b0;
            else if (fall)
                have_hi <= 1'b1;

            if (state != ST_BITS)
                bit_cnt <= '0;
            else if (bit_ev)
                bit_cnt <= bit_cnt + 5'd1;
            if (bit_ev)
                shift_q <= {shift_q[FRAME_BITS-2:0], bit_val};

            if (idle_hit) begin
                hist_vld  <= 1'b0;
                match_cnt <= '0;
            end else if (done_ev) begin
                match_cnt <= cnt_new;
                hist_vld  <= 1'b1;
                if (!same) stored <= shift_q;
            end

            pend  <= fire;
            valid <= pend;
            if (pend) data <= stored;
        end
    end

endmodule

// File: tb/tb_pt_dec.sv
// Bench for pt_dec: symbol-width table, directed frame scenarios and a randomized
// frame sequence checked against a frame-level repeat model.
module tb_pt_dec;

    localparam int A       = 16;
    localparam int MIN_REP = 2;

    typedef struct {
        int hi;
        int lo;
        bit exp_err;
        bit exp_bit;
    } sym_vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_line;
    logic [23:0] data;
    logic        valid, err;

    int cyc = 0;
    int valid_cnt = 0, err_cnt = 0, last_valid_cyc = 0, tail_start = 0;
    int tests = 0, fails = 0;

    // frame-level reference model of the repeat filter
    bit          m_have;
    logic [23:0] m_last, m_data;
    int          m_run, m_valids, m_errs;

    pt_dec #(.ALPHA(A), .MIN_REPEAT(MIN_REP)) dut (
        .clk   (clk),
        .rst   (rst),
        .in    (in_line),
        .data  (data),
        .valid (valid),
        .err   (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (valid) begin
                valid_cnt++;
                last_valid_cyc = cyc;
            end
            if (err) err_cnt++;
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: time limit reached, tests=%0d", tests);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_level(input logic v, input int n);
        in_line = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_sym(input int h, input int l);
        send_level(1'b1, h);
        send_level(1'b0, l);
    endtask

    // Frame = 24 symbols MSB first, then a short tail high and a 12-unit low.
    task automatic send_frame(input logic [23:0] f, input int pos, input int fh, input int fl);
        for (int i = 0; i < 24; i++) begin
            if (i == pos)       send_sym(fh, fl);
            else if (f[23 - i]) send_sym(3 * A, A);
            else                send_sym(A, 3 * A);
        end
        send_level(1'b1, A);
        tail_start = cyc;
        send_level(1'b0, 12 * A);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_line = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        send_level(1'b0, 200);
    endtask

    task automatic model_reset();
        m_have = 1'b0; m_last = '0; m_data = '0;
        m_run = 0; m_valids = 0; m_errs = 0;
    endtask

    task automatic model_frame(input logic [23:0] f);
        if (m_have && f == m_last) m_run++;
        else m_run = 1;
        m_have = 1'b1;
        m_last = f;
        if (m_run == MIN_REP) begin
            m_valids++;
            m_data = f;
        end
    endtask

    initial begin
        sym_vec_t    tbl [6];
        logic [23:0] payload, code;
        int          v0, e0, r, pos;

        tbl[0] = '{hi: 8,  lo: 48, exp_err: 1'b0, exp_bit: 1'b0};
        tbl[1] = '{hi: 31, lo: 32, exp_err: 1'b0, exp_bit: 1'b0};
        tbl[2] = '{hi: 64, lo: 8,  exp_err: 1'b0, exp_bit: 1'b1};
        tbl[3] = '{hi: 7,  lo: 48, exp_err: 1'b1, exp_bit: 1'b0};
        tbl[4] = '{hi: 16, lo: 65, exp_err: 1'b1, exp_bit: 1'b0};
        tbl[5] = '{hi: 48, lo: 48, exp_err: 1'b1, exp_bit: 1'b0};

        rst = 1'b1;
        in_line = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_data", 32'(data), 32'h0);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_err", 32'(err), 32'h0);
        rst = 1'b0;
        send_level(1'b0, 200);

        // symbol width boundaries, first symbol of the frame
        for (int i = 0; i < 6; i++) begin
            payload = {tbl[i].exp_bit, 23'(32'h2A5A5 + i * 32'h1111)};
            v0 = valid_cnt;
            e0 = err_cnt;
            send_frame(payload, 0, tbl[i].hi, tbl[i].lo);
            if (!tbl[i].exp_err) send_frame(payload, 0, tbl[i].hi, tbl[i].lo);
            check($sformatf("tbl%0d_err", i), 32'(err_cnt - e0), tbl[i].exp_err ? 32'd1 : 32'd0);
            check($sformatf("tbl%0d_valid", i), 32'(valid_cnt - v0), tbl[i].exp_err ? 32'd0 : 32'd1);
            if (!tbl[i].exp_err) check($sformatf("tbl%0d_data", i), 32'(data), 32'(payload));
        end

        // two identical frames: one valid, timed from the start of the second tail low
        do_reset();
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(24'hA5C30F, -1, 0, 0);
        send_frame(24'hA5C30F, -1, 0, 0);
        check("rep2_valid", 32'(valid_cnt - v0), 32'd1);
        check("rep2_data", 32'(data), 32'hA5C30F);
        check("rep2_err", 32'(err_cnt - e0), 32'd0);
        r = last_valid_cyc - tail_start;
        tests++;
        if (r < 129 || r > 136) begin
            fails++;
            $display("FAIL rep2_latency: got %0d cycles, expected 129..136", r);
        end

        // single frame then long idle: nothing reported
        do_reset();
        v0 = valid_cnt;
        send_frame(24'h123456, -1, 0, 0);
        send_level(1'b0, 1100);
        check("single_valid", 32'(valid_cnt - v0), 32'd0);
        check("single_data", 32'(data), 32'h0);

        // a different frame must not count toward the following pair
        do_reset();
        v0 = valid_cnt;
        send_frame(24'h123456, -1, 0, 0);
        send_frame(24'h654321, -1, 0, 0);
        send_frame(24'h654321, -1, 0, 0);
        check("chg_valid", 32'(valid_cnt - v0), 32'd1);
        check("chg_data", 32'(data), 32'h654321);

        // overlong high at bit 7, then recovery
        do_reset();
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(24'h0F0F0F, 7, 80, 48);
        check("long_hi_err", 32'(err_cnt - e0), 32'd1);
        check("long_hi_novalid", 32'(valid_cnt - v0), 32'd0);
        send_frame(24'h0F0F0F, -1, 0, 0);
        send_frame(24'h0F0F0F, -1, 0, 0);
        check("recover_valid", 32'(valid_cnt - v0), 32'd1);
        check("recover_data", 32'(data), 32'h0F0F0F);

        // repeats do not re-pulse; an idle gap re-arms
        do_reset();
        v0 = valid_cnt;
        for (int k = 0; k < 3; k++) send_frame(24'hFFFFFF, -1, 0, 0);
        check("sat_valid", 32'(valid_cnt - v0), 32'd1);
        send_level(1'b0, 1100);
        send_frame(24'hFFFFFF, -1, 0, 0);
        send_frame(24'hFFFFFF, -1, 0, 0);
        check("rearm_valid", 32'(valid_cnt - v0), 32'd2);
        check("rearm_data", 32'(data), 32'hFFFFFF);

        // reset in the middle of bit 12 of the second frame
        do_reset();
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(24'hAAAAAA, -1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0) send_sym(3 * A, A);
            else            send_sym(A, 3 * A);
        end
        send_level(1'b1, 20);
        rst = 1'b1;
        #1;
        check("midrst_data", 32'(data), 32'h0);
        check("midrst_valid", 32'(valid), 32'h0);
        check("midrst_err", 32'(err), 32'h0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        send_level(1'b0, 200);
        send_frame(24'hAAAAAA, -1, 0, 0);
        send_frame(24'hAAAAAA, -1, 0, 0);
        check("midrst_after_valid", 32'(valid_cnt - v0), 32'd1);
        check("midrst_after_data", 32'(data), 32'hAAAAAA);
        check("midrst_no_err", 32'(err_cnt - e0), 32'd0);

        // randomized frame sequence against the frame-level model
        do_reset();
        model_reset();
        v0 = valid_cnt; e0 = err_cnt;
        for (int it = 0; it < 6; it++) begin
            code = ($urandom_range(0, 1) == 0) ? 24'h5A5A5A : 24'h3C3C3C;
            r = $urandom_range(0, 9);
            if (r < 2) begin
                pos = $urandom_range(0, 23);
                send_frame(code, pos, 80, 48);
                m_errs++;
            end else begin
                send_frame(code, -1, 0, 0);
                model_frame(code);
            end
            if (r == 9) begin
                send_level(1'b0, 1100);
                m_have = 1'b0;
                m_run = 0;
            end
            check($sformatf("rnd%0d_valid", it), 32'(valid_cnt - v0), 32'(m_valids));
            check($sformatf("rnd%0d_data", it), 32'(data), 32'(m_data));
            check($sformatf("rnd%0d_err", it), 32'(err_cnt - e0), 32'(m_errs));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
